acc_stack_unit: RTL and testbench

Parametrised next-generation accumulator for the microcontroller datapath. It holds the working accumulator and selects its next value from the ALU, the register file or an immediate, or applies one of three shift operations. It adds a small LIFO save/restore stack of accumulator values, with status and sticky error flags. It sits between the ALU/register file and the control FSM.

---
 rtl/acc_stack_unit.sv | 131 +++++++++++++
 tb/tb_acc_stack_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_stack_unit.sv
// acc_stack_unit: working accumulator with load-source / shift select, plus a
// small LIFO save/restore stack of accumulator values with status and a sticky
// overflow/underflow error flag. All outputs come straight from registered state.
module acc_stack_unit #(
   parameter  int WIDTH = 8,
   parameter  int IMM_W = 4,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             clb,
   input  logic [WIDTH-1:0] aluin,
   input  logic [WIDTH-1:0] regin,
   input  logic [IMM_W-1:0] imm,
   input  logic [2:0]       selacc,
   input  logic             loadacc,
   input  logic             push,
   input  logic             pop,
   input  logic             clr_err,
   output logic [WIDTH-1:0] accout,
   output logic             zero,
   output logic             neg,
   output logic [CNT_W-1:0] stk_cnt,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             stk_err
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      SEL_ALU  = 3'b000,
      SEL_HOLD = 3'b001,
      SEL_REG  = 3'b010,
      SEL_IMMZ = 3'b011,
      SEL_IMMS = 3'b100,
      SEL_SHL  = 3'b101,
      SEL_SHR  = 3'b110,
      SEL_ASR  = 3'b111
   } sel_e;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [WIDTH-1:0] load_val;
   logic [IDX_W-1:0] top_idx, mem_wr_idx;
   logic             full, empty;
   logic             do_push, do_pop, do_swap, err_evt, mem_wr_en;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign top_idx = IDX_W'(cnt_q - CNT_W'(1));

   // Decode stack requests into the accepted operation and any error event.
   always_comb begin
      do_push = push & ~pop & ~full;
      do_pop  = pop & ~push & ~empty;
      do_swap = push & pop & ~empty;
      err_evt = (push & ~pop & full) | (pop & ~push & empty) | (push & pop & empty);
   end

   // Select the value loadacc would write, from sources or shifts of acc.
   always_comb begin
      load_val = acc_q;
      case (sel_e'(selacc))
         SEL_ALU:  load_val = aluin;
         SEL_HOLD: load_val = acc_q;
         SEL_REG:  load_val = regin;
         SEL_IMMZ: load_val = WIDTH'(imm);
         SEL_IMMS: load_val = WIDTH'($signed(imm));
         SEL_SHL:  load_val = {acc_q[WIDTH-2:0], 1'b0};
         SEL_SHR:  load_val = {1'b0, acc_q[WIDTH-1:1]};
         SEL_ASR:  load_val = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      endcase
   end

   // Next-state for acc, count and error: a stack restore outranks loadacc.
   always_comb begin
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      mem_wr_en  = do_push | do_swap;
      mem_wr_idx = do_swap ? top_idx : IDX_W'(cnt_q);
      if (do_pop || do_swap) begin
         acc_d = mem_q[top_idx];
      end else if (loadacc) begin
         acc_d = load_val;
      end
      if (do_push) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (do_pop) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      // A new error in the same cycle as clr_err leaves the flag set.
      err_d = err_evt ? 1'b1 : (clr_err ? 1'b0 : err_q);
   end

   // Architectural state with synchronous reset taking priority over everything.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (clb) begin
         acc_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Stack storage: write the pre-edge accumulator on push or swap.
   // NOTE: storage is deliberately not reset; entries above stk_cnt are never
   // read, so clearing them would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (mem_wr_en) begin
         mem_q[mem_wr_idx] <= acc_q;
      end
   end

   assign accout    = acc_q;
   assign zero      = (acc_q == '0);
   assign neg       = acc_q[WIDTH-1];
   assign stk_cnt   = cnt_q;
   assign stk_full  = full;
   assign stk_empty = empty;
   assign stk_err   = err_q;

endmodule

// File: tb/tb_acc_stack_unit.sv
// tb_acc_stack_unit: directed scenarios plus randomized traffic, each step
// compared against a queue-based behavioural model of the accumulator/stack.
module tb_acc_stack_unit;

   localparam int WIDTH = 8;
   localparam int IMM_W = 4;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             clb;
   logic [WIDTH-1:0] aluin, regin;
   logic [IMM_W-1:0] imm;
   logic [2:0]       selacc;
   logic             loadacc, push, pop, clr_err;
   logic [WIDTH-1:0] accout;
   logic             zero, neg, stk_full, stk_empty, stk_err;
   logic [CNT_W-1:0] stk_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_acc;
   int m_stk[$];
   bit m_err;

   acc_stack_unit #(.WIDTH(WIDTH), .IMM_W(IMM_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .clb(clb), .aluin(aluin), .regin(regin), .imm(imm),
      .selacc(selacc), .loadacc(loadacc), .push(push), .pop(pop),
      .clr_err(clr_err), .accout(accout), .zero(zero), .neg(neg),
      .stk_cnt(stk_cnt), .stk_full(stk_full), .stk_empty(stk_empty),
      .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   // Next state from the behavioural rules, using the model's pre-edge state.
   function automatic void model_step(bit rst, int a, int r, int im, int sel,
                                      bit ld, bit ps, bit pp, bit ce);
      int  ld_val;
      int  tmp;
      bit  evt = 0;
      bit  took = 0;
      case (sel)
         0: ld_val = a;
         1: ld_val = m_acc;
         2: ld_val = r;
         3: ld_val = im;
         4: ld_val = (im >= 8) ? im + 240 : im;
         5: ld_val = (m_acc * 2) % 256;
         6: ld_val = m_acc / 2;
         default: ld_val = m_acc / 2 + ((m_acc >= 128) ? 128 : 0);
      endcase
      if (rst) begin
         m_acc = 0;
         m_stk.delete();
         m_err = 0;
         return;
      end
      if (ps && pp) begin
         if (m_stk.size() > 0) begin
            tmp = m_stk[m_stk.size() - 1];
            m_stk[m_stk.size() - 1] = m_acc;
            m_acc = tmp;
            took = 1;
         end else evt = 1;
      end else if (pp) begin
         if (m_stk.size() > 0) begin
            m_acc = m_stk.pop_back();
            took = 1;
         end else evt = 1;
      end else if (ps) begin
         if (m_stk.size() < DEPTH) m_stk.push_back(m_acc);
         else evt = 1;
      end
      if (!took && ld) m_acc = ld_val;
      m_err = evt ? 1'b1 : (ce ? 1'b0 : m_err);
   endfunction

   function automatic logic [15:0] exp_vec();
      int n = m_stk.size();
      return {8'(m_acc), m_acc == 0, m_acc >= 128, 3'(n), n == DEPTH, n == 0, m_err};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {accout, zero, neg, stk_cnt, stk_full, stk_empty, stk_err};
   endfunction

   // One clock: apply inputs, advance model at the edge, sample 1 time unit later.
   task automatic drive(input bit rst, input int a, input int r, input int im,
                        input int sel, input bit ld, input bit ps, input bit pp,
                        input bit ce);
      clb = rst; aluin = 8'(a); regin = 8'(r); imm = 4'(im); selacc = 3'(sel);
      loadacc = ld; push = ps; pop = pp; clr_err = ce;
      @(posedge clk);
      model_step(rst, a, r, im, sel, ld, ps, pp, ce);
      #1;
   endtask

   task automatic test_reset();
      drive(1, 8'hFF, 8'hFF, 4'hF, 0, 1, 1, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
      end
      checks++;
      if ({accout, zero, neg, stk_empty, stk_full, stk_err} !== {8'h00, 5'b10100}) begin
         errors++;
         $display("FAIL reset_flags: got acc=%h z=%b n=%b e=%b f=%b err=%b expected 00 1 0 1 0 0",
                  accout, zero, neg, stk_empty, stk_full, stk_err);
      end
   endtask

   task automatic test_load_modes();
      drive(0, 8'hA5, 8'h3C, 0, 0, 1, 0, 0, 0);
      checks++;
      if ({accout, neg} !== {8'hA5, 1'b1}) begin
         errors++; $display("FAIL load_alu: got %h neg=%b expected a5 neg=1", accout, neg);
      end
      drive(0, 8'h11, 8'h00, 0, 2, 1, 0, 0, 0);
      checks++;
      if ({accout, zero} !== {8'h00, 1'b1}) begin
         errors++; $display("FAIL load_reg: got %h zero=%b expected 00 zero=1", accout, zero);
      end
      drive(0, 0, 0, 4'hC, 3, 1, 0, 0, 0);
      checks++;
      if (accout !== 8'h0C) begin
         errors++; $display("FAIL load_immz: got %h expected 0c", accout);
      end
      drive(0, 0, 0, 4'hC, 4, 1, 0, 0, 0);
      checks++;
      if (accout !== 8'hFC) begin
         errors++; $display("FAIL load_imms: got %h expected fc", accout);
      end
      drive(0, 0, 0, 4'h5, 4, 1, 0, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL load_imms_pos: got %h expected %h", obs_vec(), exp_vec());
      end
      drive(0, 8'h77, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (accout !== 8'h05) begin
         errors++; $display("FAIL load_disabled: got %h expected 05", accout);
      end
   endtask

   task automatic test_shifts();
      int exp_v[3] = '{8'h02, 8'h40, 8'hC0};
      for (int i = 0; i < 3; i++) begin
         drive(0, 8'h81, 0, 0, 0, 1, 0, 0, 0);
         drive(0, 0, 0, 0, 5 + i, 1, 0, 0, 0);
         checks++;
         if (accout !== 8'(exp_v[i])) begin
            errors++; $display("FAIL shift_sel%0d: got %h expected %h", 5 + i, accout, 8'(exp_v[i]));
         end
      end
      drive(0, 8'h12, 8'h34, 4'h1, 1, 1, 0, 0, 0);
      checks++;
      if (accout !== 8'hC0) begin
         errors++; $display("FAIL shift_hold: got %h expected c0", accout);
      end
   endtask

   task automatic test_lifo();
      int vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         drive(0, vals[i], 0, 0, 0, 1, 0, 0, 0);
         drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      end
      checks++;
      if ({stk_full, stk_cnt} !== {1'b1, 3'd4}) begin
         errors++; $display("FAIL lifo_full: got full=%b cnt=%0d expected full=1 cnt=4", stk_full, stk_cnt);
      end
      for (int i = 3; i >= 0; i--) begin
         drive(0, 8'hEE, 0, 0, 0, 0, 0, 1, 0);
         checks++;
         if (accout !== 8'(vals[i])) begin
            errors++; $display("FAIL lifo_pop%0d: got %h expected %h", 3 - i, accout, 8'(vals[i]));
         end
      end
      checks++;
      if ({stk_empty, stk_err} !== 2'b10) begin
         errors++; $display("FAIL lifo_empty: got empty=%b err=%b expected empty=1 err=0", stk_empty, stk_err);
      end
   endtask

   task automatic test_errors();
      for (int i = 0; i < 4; i++) begin
         drive(0, 8'h20 + i, 0, 0, 0, 1, 0, 0, 0);
         drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      end
      drive(0, 8'h9A, 0, 0, 0, 1, 1, 0, 0);
      checks++;
      if ({stk_cnt, stk_err, accout} !== {3'd4, 1'b1, 8'h9A}) begin
         errors++; $display("FAIL err_overflow: got cnt=%0d err=%b acc=%h expected 4 1 9a", stk_cnt, stk_err, accout);
      end
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (stk_err !== 1'b1) begin
         errors++; $display("FAIL err_sticky: got %b expected 1", stk_err);
      end
      drive(0, 0, 0, 0, 1, 0, 0, 0, 1);
      checks++;
      if (stk_err !== 1'b0) begin
         errors++; $display("FAIL err_clear: got %b expected 0", stk_err);
      end
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 1, 0, 0, 1, 0);
      checks++;
      if ({stk_err, stk_cnt, accout} !== {1'b1, 3'd0, 8'h20}) begin
         errors++; $display("FAIL err_underflow: got err=%b cnt=%0d acc=%h expected 1 0 20", stk_err, stk_cnt, accout);
      end
      drive(0, 0, 0, 0, 1, 0, 0, 1, 1);
      checks++;
      if (stk_err !== 1'b1) begin
         errors++; $display("FAIL err_set_wins: got %b expected 1", stk_err);
      end
      drive(0, 0, 0, 0, 1, 0, 0, 0, 1);
   endtask

   task automatic test_back_to_back();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 8'h66, 0, 0, 0, 1, 0, 0, 0);
      drive(0, 8'h55, 0, 0, 0, 1, 1, 0, 0);
      drive(0, 8'hAA, 0, 0, 0, 1, 1, 1, 0);
      checks++;
      if ({accout, stk_cnt} !== {8'h66, 3'd1}) begin
         errors++; $display("FAIL swap: got acc=%h cnt=%0d expected 66 1", accout, stk_cnt);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (accout !== 8'h55) begin
         errors++; $display("FAIL swap_pop: got %h expected 55", accout);
      end
      drive(0, 8'h77, 0, 0, 0, 1, 1, 0, 0);
      checks++;
      if ({accout, stk_cnt} !== {8'h77, 3'd1}) begin
         errors++; $display("FAIL push_load: got acc=%h cnt=%0d expected 77 1", accout, stk_cnt);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (accout !== 8'h55) begin
         errors++; $display("FAIL push_load_pop: got %h expected 55", accout);
      end
      drive(0, 8'h99, 0, 0, 0, 1, 1, 0, 0);
      drive(0, 8'h33, 0, 0, 0, 1, 0, 1, 0);
      checks++;
      if (accout !== 8'h55) begin
         errors++; $display("FAIL pop_over_load: got %h expected 55", accout);
      end
      drive(0, 8'h3C, 0, 0, 0, 1, 1, 1, 0);
      checks++;
      if ({accout, stk_err, stk_cnt} !== {8'h3C, 1'b1, 3'd0}) begin
         errors++; $display("FAIL swap_empty: got acc=%h err=%b cnt=%0d expected 3c 1 0", accout, stk_err, stk_cnt);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) drive(0, 8'h40 + i, 0, 0, 0, 1, 1, 0, 0);
      checks++;
      if ({stk_cnt, stk_err} !== {3'd3, 1'b1}) begin
         errors++; $display("FAIL mid_setup: got cnt=%0d err=%b expected 3 1", stk_cnt, stk_err);
      end
      drive(1, 8'hFF, 0, 0, 0, 1, 1, 0, 0);
      checks++;
      if ({accout, stk_cnt, stk_err} !== {8'h00, 3'd0, 1'b0}) begin
         errors++; $display("FAIL mid_reset: got acc=%h cnt=%0d err=%b expected 00 0 0", accout, stk_cnt, stk_err);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            if (bad < 10) $display("FAIL random_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
            bad++;
         end
      end
   endtask

   initial begin
      clb = 1'b1; aluin = '0; regin = '0; imm = '0; selacc = '0;
      loadacc = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
      m_acc = 0; m_err = 0;
      #2;
      test_reset();
      test_load_modes();
      test_shifts();
      test_lifo();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
